// File: rtl/waveform_to_pipe_bram.sv
// ---------------------------------------------------------------------------
// waveform_to_pipe_bram
//
// This module captures a triggered burst of 32-bit waveform samples into
// block RAM. It then returns the burst to the host as 16-bit pipe-out words.
// Pipe word 2i is sample i [15:0] and pipe word 2i+1 is sample i [31:16].
// All logic and both RAM ports run on pipe_clk.
//
// Ports
//   pipe_clk       clock for all logic and both RAM ports
//   reset          synchronous, active-high reset
//   arm            one-cycle request to start a new capture
//   trigger        starts recording once the block is armed
//   sample_valid   qualifies sample_data in this cycle
//   sample_data    32-bit waveform sample
//   pipe_out_read  host read strobe, one word per high cycle
//   pipe_out_data  registered 16-bit pipe-out word (one-cycle latency)
//   capture_done   buffer is full and not yet fully read
//   state          0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE, 4 READOUT
//   sample_count   samples written in the current capture
//   read_count     pipe words delivered in the current readout
// ---------------------------------------------------------------------------
module waveform_to_pipe_bram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  pipe_clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  trigger,
    input  logic                  sample_valid,
    input  logic [31:0]           sample_data,
    input  logic                  pipe_out_read,
    output logic [15:0]           pipe_out_data,
    output logic                  capture_done,
    output logic [2:0]            state,
    output logic [DEPTH_LOG2:0]   sample_count,
    output logic [DEPTH_LOG2+1:0] read_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   SAMPLE_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2+1:0] WORD_LAST   = (DEPTH_LOG2 + 2)'(2 * DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DONE    = 3'd3,
        ST_READOUT = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2:0]   sample_count_q, sample_count_d;
    logic [DEPTH_LOG2+1:0] read_count_q, read_count_d;
    logic [DEPTH_LOG2:0]   sample_inc;
    logic [15:0]           pipe_out_data_q;
    logic                  wr_en;
    logic                  rd_en;
    logic                  rd_zero;

    logic [31:0] mem_q [DEPTH];

    assign sample_inc = sample_count_q + 1'b1;

    // ------------------------------------------------------------------
    // Next-state and control logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case. Without the
        // defaults, a path that leaves a signal unassigned infers a latch.
        state_d        = state_q;
        sample_count_d = sample_count_q;
        read_count_d   = read_count_q;
        wr_en          = 1'b0;
        rd_en          = 1'b0;
        rd_zero        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rd_zero = pipe_out_read;
                if (arm) begin
                    state_d        = ST_ARMED;
                    sample_count_d = '0;
                    read_count_d   = '0;
                end
            end

            // ARMED and CAPTURE share the write path. In ARMED, a sample is
            // written only when trigger arrives with it in the same cycle.
            // That sample lands at address 0, because the counter was
            // cleared when the block was armed.
            ST_ARMED, ST_CAPTURE: begin
                rd_zero = pipe_out_read;
                if (state_q == ST_ARMED && trigger) begin
                    state_d = ST_CAPTURE;
                end
                if (sample_valid && (state_q == ST_CAPTURE || trigger)) begin
                    wr_en          = 1'b1;
                    sample_count_d = sample_inc;
                    if (sample_inc == SAMPLE_FULL) begin
                        state_d = ST_DONE;
                    end
                end
            end

            // When arm and a read strobe arrive together, arm wins. The
            // buffer is abandoned and pipe_out_data keeps its value.
            ST_DONE, ST_READOUT: begin
                if (arm) begin
                    state_d        = ST_ARMED;
                    sample_count_d = '0;
                    read_count_d   = '0;
                end else if (pipe_out_read) begin
                    rd_en        = 1'b1;
                    read_count_d = read_count_q + 1'b1;
                    state_d      = (read_count_q == WORD_LAST) ? ST_IDLE : ST_READOUT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge pipe_clk) begin
        // NOTE: sequential state is updated with non-blocking assignments,
        // so every register samples values from before this edge.
        if (reset) begin
            state_q        <= ST_IDLE;
            sample_count_q <= '0;
            read_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            sample_count_q <= sample_count_d;
            read_count_q   <= read_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Sample buffer, write port
    // ------------------------------------------------------------------
    // NOTE: the memory array is kept out of the reset branch on purpose.
    // Resetting it would stop block-RAM inference, and its contents only
    // matter after a completed capture.
    always_ff @(posedge pipe_clk) begin
        if (wr_en) begin
            mem_q[sample_count_q[DEPTH_LOG2-1:0]] <= sample_data;
        end
    end

    // ------------------------------------------------------------------
    // Sample buffer, read port with registered 16-bit output
    // ------------------------------------------------------------------
    // read_count[0] selects the half-word, and the upper bits select the
    // sample. A strobe outside DONE/READOUT returns zero. In every other
    // case the output holds between strobes.
    always_ff @(posedge pipe_clk) begin
        if (reset) begin
            pipe_out_data_q <= 16'h0000;
        end else if (rd_en) begin
            pipe_out_data_q <= read_count_q[0]
                ? mem_q[read_count_q[DEPTH_LOG2:1]][31:16]
                : mem_q[read_count_q[DEPTH_LOG2:1]][15:0];
        end else if (rd_zero) begin
            pipe_out_data_q <= 16'h0000;
        end
    end

    assign pipe_out_data = pipe_out_data_q;
    assign capture_done  = (state_q == ST_DONE) || (state_q == ST_READOUT);
    assign state         = state_q;
    assign sample_count  = sample_count_q;
    assign read_count    = read_count_q;

endmodule

// File: tb/tb_waveform_to_pipe_bram.sv
// ---------------------------------------------------------------------------
// tb_waveform_to_pipe_bram
//
// Directed, self-checking bench for waveform_to_pipe_bram with DEPTH_LOG2=4
// (16 samples, 32 pipe words). Inputs change 1 ns after each rising edge, and
// outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_waveform_to_pipe_bram;

    localparam int DL2 = 4;

    logic           pipe_clk;
    logic           reset;
    logic           arm;
    logic           trigger;
    logic           sample_valid;
    logic [31:0]    sample_data;
    logic           pipe_out_read;
    logic [15:0]    pipe_out_data;
    logic           capture_done;
    logic [2:0]     state;
    logic [DL2:0]   sample_count;
    logic [DL2+1:0] read_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_mem [16];

    waveform_to_pipe_bram #(.DEPTH_LOG2(DL2)) dut (
        .pipe_clk      (pipe_clk),
        .reset         (reset),
        .arm           (arm),
        .trigger       (trigger),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .pipe_out_read (pipe_out_read),
        .pipe_out_data (pipe_out_data),
        .capture_done  (capture_done),
        .state         (state),
        .sample_count  (sample_count),
        .read_count    (read_count)
    );

    initial pipe_clk = 1'b0;
    always #5 pipe_clk = ~pipe_clk;

    task automatic step();
        @(posedge pipe_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input int w);
        logic [31:0] s;
        s = exp_mem[w >> 1];
        return (w % 2 == 1) ? s[31:16] : s[15:0];
    endfunction

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic do_trigger();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
    endtask

    // Back-to-back samples base + i*stride for i in [first, 15].
    task automatic capture_from(input int first, input logic [31:0] base, input logic [31:0] stride);
        for (int i = first; i < 16; i++) begin
            sample_valid = 1'b1;
            sample_data  = base + i * stride;
            exp_mem[i]   = base + i * stride;
            step();
        end
        sample_valid = 1'b0;
    endtask

    // Reads words [first, last] back to back and checks each one a cycle
    // after its strobe.
    task automatic read_words(input string tag, input int first, input int last);
        for (int w = first; w <= last; w++) begin
            pipe_out_read = 1'b1;
            step();
            check($sformatf("%s_w%0d", tag, w), 32'(pipe_out_data), 32'(exp_word(w)));
        end
        pipe_out_read = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        arm           = 1'b0;
        trigger       = 1'b0;
        sample_valid  = 1'b0;
        sample_data   = '0;
        pipe_out_read = 1'b0;

        // ---- Reset ----
        step();
        step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_done",  32'(capture_done), 32'd0);
        check("rst_scnt",  32'(sample_count), 32'd0);
        check("rst_rcnt",  32'(read_count), 32'd0);
        check("rst_data",  32'(pipe_out_data), 32'h0);
        reset = 1'b0;

        // ---- Full capture and readout ----
        do_arm();
        check("t2_armed", 32'(state), 32'd1);
        do_trigger();
        check("t2_capture", 32'(state), 32'd2);
        check("t2_scnt0", 32'(sample_count), 32'd0);
        capture_from(0, 32'hA000_0000, 32'd1);
        check("t2_done_state", 32'(state), 32'd3);
        check("t2_done_flag", 32'(capture_done), 32'd1);
        check("t2_scnt16", 32'(sample_count), 32'd16);
        read_words("t2", 0, 31);
        check("t2_idle", 32'(state), 32'd0);
        check("t2_done_clr", 32'(capture_done), 32'd0);
        check("t2_rcnt32", 32'(read_count), 32'd32);

        // ---- Ignored events in IDLE ----
        sample_valid  = 1'b1;
        trigger       = 1'b1;
        sample_data   = 32'hDEAD_BEEF;
        pipe_out_read = 1'b1;
        step();
        sample_valid  = 1'b0;
        trigger       = 1'b0;
        pipe_out_read = 1'b0;
        check("ign_state", 32'(state), 32'd0);
        check("ign_scnt", 32'(sample_count), 32'd16);
        check("ign_rcnt", 32'(read_count), 32'd32);
        check("ign_data", 32'(pipe_out_data), 32'h0);

        // ---- Coincident trigger and gapped samples ----
        do_arm();
        check("t3_armed", 32'(state), 32'd1);
        check("t3_scnt_clr", 32'(sample_count), 32'd0);
        check("t3_rcnt_clr", 32'(read_count), 32'd0);
        trigger      = 1'b1;
        sample_valid = 1'b1;
        sample_data  = 32'h1234_5678;
        exp_mem[0]   = 32'h1234_5678;
        step();
        trigger      = 1'b0;
        sample_valid = 1'b0;
        check("t3_cap", 32'(state), 32'd2);
        check("t3_scnt1", 32'(sample_count), 32'd1);
        for (int i = 1; i < 16; i++) begin
            for (int g = 0; g < i % 3; g++) step();
            sample_valid = 1'b1;
            sample_data  = 32'h5000_0000 + i * 32'h0001_0101;
            exp_mem[i]   = 32'h5000_0000 + i * 32'h0001_0101;
            step();
            sample_valid = 1'b0;
            if (i == 7) begin
                pipe_out_read = 1'b1;
                step();
                pipe_out_read = 1'b0;
                check("cap_rd_data", 32'(pipe_out_data), 32'h0);
                check("cap_rd_rcnt", 32'(read_count), 32'd0);
                check("cap_rd_scnt", 32'(sample_count), 32'd8);
                arm     = 1'b1;
                trigger = 1'b1;
                step();
                arm     = 1'b0;
                trigger = 1'b0;
                check("cap_arm_state", 32'(state), 32'd2);
                check("cap_arm_scnt", 32'(sample_count), 32'd8);
            end
        end
        check("t3_done", 32'(state), 32'd3);
        check("t3_scnt16", 32'(sample_count), 32'd16);
        pipe_out_read = 1'b1;
        step();
        check("t3_word0", 32'(pipe_out_data), 32'h5678);
        step();
        pipe_out_read = 1'b0;
        check("t3_word1", 32'(pipe_out_data), 32'h1234);
        read_words("t3", 2, 4);
        step();
        step();
        check("t3_hold", 32'(pipe_out_data), 32'(exp_word(4)));
        check("t3_readout", 32'(state), 32'd4);
        check("t3_rcnt5", 32'(read_count), 32'd5);

        // ---- Re-arm during READOUT ----
        do_arm();
        check("rearm_state", 32'(state), 32'd1);
        check("rearm_rcnt", 32'(read_count), 32'd0);
        check("rearm_scnt", 32'(sample_count), 32'd0);
        check("rearm_done", 32'(capture_done), 32'd0);

        // ---- Complete capture, full readout, over-read ----
        do_trigger();
        capture_from(0, 32'hC0DE_0000, 32'h0001_0003);
        check("t4_done", 32'(capture_done), 32'd1);
        read_words("t4", 0, 31);
        for (int k = 0; k < 2; k++) begin
            pipe_out_read = 1'b1;
            step();
            check("over_data", 32'(pipe_out_data), 32'h0);
            check("over_rcnt", 32'(read_count), 32'd32);
        end
        pipe_out_read = 1'b0;
        check("over_state", 32'(state), 32'd0);

        // ---- Reset mid-capture ----
        do_arm();
        do_trigger();
        for (int i = 0; i < 7; i++) begin
            sample_valid = 1'b1;
            sample_data  = 32'hFFFF_FFFF;
            step();
        end
        sample_valid = 1'b0;
        check("pre_rst_scnt", 32'(sample_count), 32'd7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_scnt", 32'(sample_count), 32'd0);
        check("mid_rst_rcnt", 32'(read_count), 32'd0);
        check("mid_rst_done", 32'(capture_done), 32'd0);
        do_arm();
        do_trigger();
        capture_from(0, 32'h3C00_0000, 32'h0000_0101);
        check("t5_scnt16", 32'(sample_count), 32'd16);
        read_words("t5", 0, 31);
        check("t5_idle", 32'(state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
